// File: rtl/assoc_cache_if.sv
// CPU-side and memory-side handshake bundle for assoc_cache.
// The slave modport is the cache itself; master is its environment.
interface assoc_cache_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                cpu_req;
   logic                cpu_we;
   logic [DATA_W/8-1:0] cpu_be;
   logic [ADDR_W-1:0]   cpu_addr;
   logic [DATA_W-1:0]   cpu_wdata;
   logic [DATA_W-1:0]   cpu_rdata;
   logic                cpu_ready;
   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_ack;

   modport slave (
      input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/assoc_cache.sv
// Set-associative write-back cache, one word per line, true-LRU ages.
// Blocking: one CPU access in flight, optional write-back then fill.
module assoc_cache #(
   parameter int SETS   = 8,
   parameter int WAYS   = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   assoc_cache_if.slave bus,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int IDX   = $clog2(SETS);
   localparam int AW    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = ADDR_W - 2 - IDX;
   localparam int NB    = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;
   state_t state, state_nx;

   logic              vld   [SETS][WAYS];
   logic              dty   [SETS][WAYS];
   logic [TAG_W-1:0]  tags  [SETS][WAYS];
   logic [DATA_W-1:0] lines [SETS][WAYS];
   logic [AW-1:0]     age   [SETS][WAYS];

   logic [IDX-1:0]    idx;
   logic [TAG_W-1:0]  tag;
   logic              hit, found, lookup, fill_done, touch;
   logic [AW-1:0]     hway, vsel, vway, tway;
   logic [DATA_W-1:0] base, word_nx;
   logic              unused_addr;

   assign idx         = bus.cpu_addr[2+IDX-1:2];
   assign tag         = bus.cpu_addr[ADDR_W-1:2+IDX];
   assign unused_addr = ^bus.cpu_addr[1:0];

   function automatic logic [DATA_W-1:0] merge(
      input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] wd,
      input logic [NB-1:0]     be
   );
      logic [DATA_W-1:0] r;
      r = old;
      for (int b = 0; b < NB; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always_comb begin
      hit   = 1'b0;
      hway  = '0;
      found = 1'b0;
      vsel  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (vld[idx][w] && tags[idx][w] == tag) begin
            hit  = 1'b1;
            hway = AW'(w);
         end
         if (!vld[idx][w] && !found) begin
            found = 1'b1;
            vsel  = AW'(w);
         end
      end
      // ages are a permutation, so the oldest way has age WAYS-1
      if (!found)
         for (int w = 0; w < WAYS; w++)
            if (int'(age[idx][w]) == WAYS - 1) vsel = AW'(w);
   end

   assign lookup    = (state == IDLE) && bus.cpu_req;
   assign fill_done = (state == FILL) && bus.mem_ack;
   assign touch     = (lookup && hit) || fill_done;
   assign tway      = fill_done ? vway : hway;
   assign base      = fill_done ? bus.mem_rdata : lines[idx][hway];
   assign word_nx   = bus.cpu_we ?
                      merge(base, bus.cpu_wdata, bus.cpu_be) : base;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.cpu_ready = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      unique case (state)
         IDLE: begin
            if (bus.cpu_req) begin
               if (hit)
                  state_nx = RESP;
               else if (vld[idx][vsel] && dty[idx][vsel])
                  state_nx = WB;
               else
                  state_nx = FILL;
            end
         end
         WB: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {tags[idx][vway], idx, 2'b00};
            bus.mem_wdata = lines[idx][vway];
            if (bus.mem_ack) state_nx = FILL;
         end
         FILL: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {tag, idx, 2'b00};
            if (bus.mem_ack) state_nx = RESP;
         end
         RESP: begin
            bus.cpu_ready = 1'b1;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
               vld[s][w]   <= 1'b0;
               dty[s][w]   <= 1'b0;
               tags[s][w]  <= '0;
               lines[s][w] <= '0;
               age[s][w]   <= AW'(w);
            end
         vway          <= '0;
         bus.cpu_rdata <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
      end else begin
         if (lookup && !hit) begin
            vway <= vsel;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
         end
         if (lookup && hit && hit_cnt != '1)
            hit_cnt <= hit_cnt + 32'd1;
         if (touch) begin
            lines[idx][tway] <= word_nx;
            vld[idx][tway]   <= 1'b1;
            tags[idx][tway]  <= tag;
            bus.cpu_rdata    <= word_nx;
            if (bus.cpu_we)     dty[idx][tway] <= 1'b1;
            else if (fill_done) dty[idx][tway] <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
               if (w == int'(tway))
                  age[idx][w] <= '0;
               else if (age[idx][w] < age[idx][tway])
                  age[idx][w] <= age[idx][w] + 1'b1;
            end
         end
      end
   end
endmodule
